// File: rtl/pipelined_normalizer.sv
// pipelined_normalizer
//   Two-stage mantissa normaliser with valid/ready handshakes on both sides.
//   Stage 1 locates the leading significant bit and registers the left-shift
//   amount. Stage 2 applies the shift so the significant bit lands at the MSB.
//   MODE 0 normalises on the leading one (unsigned operand).
//   MODE 1 normalises on the leading sign change (two's-complement operand).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand valid
//   in_ready   block can accept an operand this cycle
//   in_data    operand (WIDTH bits)
//   in_tag     sideband carried unchanged with the operand
//   out_valid  result valid
//   out_ready  downstream accepts the result
//   out_data   normalised operand
//   out_shift  left-shift amount that was applied
//   out_zero   operand was all-zero
//   out_tag    sideband of this result
module pipelined_normalizer #(
  parameter int WIDTH     = 8,
  parameter int TAG_WIDTH = 8,
  parameter int MODE      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(WIDTH)-1:0] out_shift,
  output logic                     out_zero,
  output logic [TAG_WIDTH-1:0]     out_tag
);

  localparam int SW = $clog2(WIDTH);

  // Stage 1 state
  logic                 s1_valid_q;
  logic [WIDTH-1:0]     s1_data_q;
  logic [TAG_WIDTH-1:0] s1_tag_q;
  logic [SW-1:0]        s1_shift_q;
  logic                 s1_zero_q;

  // Stage 2 state (drives the outputs directly)
  logic                 s2_valid_q;
  logic [WIDTH-1:0]     s2_data_q;
  logic [TAG_WIDTH-1:0] s2_tag_q;
  logic [SW-1:0]        s2_shift_q;
  logic                 s2_zero_q;

  // Next-state values
  logic [SW-1:0]        s1_shift_d;
  logic                 s1_zero_d;
  logic [WIDTH-1:0]     s2_data_d;

  logic                 s1_adv;
  logic                 s2_adv;

  // Stall chain: a stage may load when it is empty or its contents move on.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Significance vector: the highest set bit of sig is the position p that
  // must end up at the MSB, so shift = WIDTH-1-p in both modes.
  //   MODE 0: sig is the operand itself.
  //   MODE 1: sig[i+1] flags data[i] differing from the sign bit; sig[0] is
  //           forced high so an operand made only of sign bits (0 or -1)
  //           yields the maximum shift of WIDTH-1.
  logic [WIDTH-1:0] sig;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sig
      if (MODE == 0) begin : g_lone
        assign sig[gi] = in_data[gi];
      end else if (gi == 0) begin : g_floor
        assign sig[gi] = 1'b1;
      end else begin : g_lsign
        assign sig[gi] = in_data[gi-1] ^ in_data[WIDTH-1];
      end
    end
  endgenerate

  // Priority encoder on sig; ascending scan so the highest hit wins.
  always_comb begin
    s1_shift_d = '0;
    s1_zero_d  = (in_data == '0);
    for (int i = 0; i < WIDTH; i++) begin
      if (sig[i]) begin
        s1_shift_d = SW'(WIDTH - 1 - i);
      end
    end
    // A zero operand is reported with no shift, regardless of mode.
    if (s1_zero_d) begin
      s1_shift_d = '0;
    end
  end

  // Zero-filled left shift into stage 2.
  assign s2_data_d = s1_data_q << s1_shift_q;

  // Payload registers only load alongside a valid beat, so idle cycles and
  // bubbles leave the outputs untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_tag_q   <= '0;
      s1_shift_q <= '0;
      s1_zero_q  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q  <= in_data;
        s1_tag_q   <= in_tag;
        s1_shift_q <= s1_shift_d;
        s1_zero_q  <= s1_zero_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_tag_q   <= '0;
      s2_shift_q <= '0;
      s2_zero_q  <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q  <= s2_data_d;
        s2_tag_q   <= s1_tag_q;
        s2_shift_q <= s1_shift_q;
        s2_zero_q  <= s1_zero_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_shift = s2_shift_q;
  assign out_zero  = s2_zero_q;
  assign out_tag   = s2_tag_q;

endmodule

// File: doc/pipelined_normalizer.md
Name: pipelined_normalizer

Overview:
- Two-stage pipelined mantissa normaliser with valid/ready handshakes on both sides.
- Stage 1 finds the leading significant bit and computes the shift amount. Stage 2 left-shifts the operand so the significant bit lands at the MSB.
- Sits between the floating-point adder/multiplier datapath and the rounding/exponent-adjust logic. It replaces the combinational leading-one detection and its separate shifter.
- MODE selects unsigned leading-one or two's-complement leading-sign normalisation.

Parameters:
- WIDTH, 8, operand width in bits; must be >= 2.
- TAG_WIDTH, 8, width of the sideband tag carried alongside each operand, e.g. exponent or sign.
- MODE, 0, 0 = leading-one (unsigned); 1 = leading-sign (two's complement).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input operand valid
- in_ready  output  1  block can accept input this cycle
- in_data  input  WIDTH  operand
- in_tag  input  TAG_WIDTH  sideband, passed through unchanged
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_data  output  WIDTH  normalised operand
- out_shift  output  $clog2(WIDTH)  left-shift amount applied
- out_zero  output  1  operand was all-zero
- out_tag  output  TAG_WIDTH  tag of this result

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset: s1_valid=0, s2_valid=0, hence out_valid=0. out_data, out_shift, out_zero and out_tag all reset to 0. Reset asserted mid-operation discards all in-flight operands immediately. No output beat follows reset release until new input is accepted.
- Transfers: an input transfer occurs when in_valid && in_ready at a rising edge. An output transfer occurs when out_valid && out_ready.
- Stall logic (combinational):
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv
- in_ready never depends on in_valid.
- Stage 1 register, loaded when in_ready:
  - s1_valid <= in_valid
  - capture data and tag
  - shift = WIDTH-1-p, where p is the highest index of a significant bit
  - zero flag
- Significant bit definition:
  - MODE 0: highest index with data bit = 1.
  - MODE 1: highest index i <= WIDTH-2 with data[i] != data[WIDTH-1], then p = i+1. If no such i exists (all bits equal to the MSB), shift = WIDTH-1.
- Zero handling: in_data == 0 gives zero=1 and shift=0 in both modes; the result is out_data=0.
- Stage 2 register, loaded when s2_adv:
  - s2_valid <= s1_valid
  - out_data <= s1_data << s1_shift, zero-filled from the LSB
  - shift, zero and tag are passed through.
- Hold rule: while out_valid && !out_ready, all outputs stay stable.
- Latency and ordering: an input accepted at edge N appears with out_valid=1 after edge N+1 when unstalled, i.e. registered at stage 2 on edge N+1. Order is strictly FIFO.
- Throughput: 1 operand/cycle with out_ready held high.
- Capacity: up to 2 operands can be buffered. With out_ready low and both stages full, in_ready=0.
- Simultaneous events: out_ready rising in the same cycle as in_valid with both stages full gives in_ready=1 that cycle. The result leaves, stage 1 moves to stage 2, and the new operand enters stage 1; no bubble and no loss.
- Outputs are registered; out_shift is less than WIDTH.
- MODE 1 result guarantee: out_data[WIDTH-1] != out_data[WIDTH-2], except for inputs 0 and all-ones (-1), where -1 yields 100…0.

Test Plan:
1. MODE 0, WIDTH 8, out_ready=1; feed 0x16, 0x80, 0x01 back-to-back -> outputs (0xB0, shift 3), (0x80, shift 0), (0x80, shift 7), zero=0. Each appears exactly one cycle after the edge it was accepted on, consecutive cycles, tags preserved.
2. MODE 0, in_data=0x00 with tag 0x5A -> out_data=0x00, out_shift=0, out_zero=1, out_tag=0x5A.
3. Backpressure: out_ready=0; offer 4 operands (A..D) continuously.
   - A and B are accepted, then in_ready=0 and out_data holds A.
   - Raise out_ready -> A, B, C, D emerge in order, with in_ready=1 in the cycle out_ready rises. No duplicates, no drops.
4. MODE 1, WIDTH 8:
   - 0xE5 -> out_data=0x94, shift 2
   - 0x1F -> out_data=0x7C, shift 2
   - 0xFF -> out_data=0x80, shift 7
   - 0x00 -> out_zero=1
5. Reset mid-operation: both stages full, out_ready=0; pulse rst_n low asynchronously (between edges) -> out_valid drops immediately, all outputs 0. After release with in_valid=0, out_valid stays 0.
6. Random stream, 10k operands, random in_valid/out_ready, WIDTH 8 and 24 -> every result matches the reference model (shift = leading-zero or leading-sign count), in order, with no loss.
